dpll: RTL and testbench
=======================

DPLL -- requirements
Module: dpll

Interface
REQ-001 Parameter PW, default 32, phase accumulator and frequency step width in bits (range 8..48).
REQ-002 Parameter OPW, default 8, width of o_phase (OPW <= PW).
REQ-003 Parameter DEFAULT_STEP, default 32'h0100_0000, frequency step loaded at reset.
REQ-004 Parameter LOCK_CNT, default 16, number of consecutive in-window reference edges needed to declare lock.
REQ-005 i_clk  input  1  system clock; all state changes on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_ce  input  1  sample enable; the loop advances only on cycles where i_ce=1.
REQ-008 i_ld  input  1  load strobe for i_step.
REQ-009 i_step  input  PW  unsigned frequency step to load.
REQ-010 i_input  input  1  reference square wave, sampled on i_ce cycles.
REQ-011 i_lgcoeff  input  5  loop-gain shift; a larger value gives a narrower loop bandwidth.
REQ-012 o_phase  output  OPW  top OPW bits of the phase accumulator.
REQ-013 o_clk  output  1  recovered clock, equal to ~phase[PW-1].
REQ-014 o_err  output  2  phase-detector result, two's complement: +1, 0 or -1.
REQ-015 o_step  output  PW  current frequency step.
REQ-016 o_locked  output  1  lock indicator.

Function
REQ-017 Reference edge: a cycle with i_ce=1, i_input=1 and the registered previous sample of i_input equal to 0.
REQ-018 The previous-sample register updates only on i_ce cycles.
REQ-019 Phase detector, evaluated on a reference edge using the phase before update:
- phase==0 gives err=0.
- phase[PW-1]=0 (NCO ahead) gives err=-1.
- phase[PW-1]=1 (NCO behind) gives err=+1.
- Any cycle without a reference edge gives err=0.
REQ-020 Proportional correction is P = 2^(PW-2) >> i_lgcoeff.
REQ-021 Integral correction is F = 2^(PW-2) >> (2*i_lgcoeff); F=0 when 2*i_lgcoeff >= PW-2.
REQ-022 On an i_ce cycle with i_ld=0: phase <= phase + step + err*P, modulo 2^PW (wraps silently).
REQ-023 On the same i_ce cycle: step <= step + err*F, saturated to [1, 2^(PW-1)-1].
REQ-024 i_ld=1 takes precedence regardless of i_ce:
- step <= clamp(i_step) to the same range.
- The lock counter and o_locked clear.
- If i_ce=1 in the same cycle, phase <= phase + clamp(i_step) with no correction, and o_err=0.
REQ-025 When i_ce=0 and i_ld=0, all state holds and o_err=0.
REQ-026 All outputs are registered, with 1-cycle latency from the i_ce cycle to the visible phase, step and err.
REQ-027 Lock window: a reference edge is in-window when the top two phase bits are 2'b00 or 2'b11 (|phase error| < 1/4 cycle).
REQ-028 Lock counter:
- An in-window edge increments the counter, saturating at LOCK_CNT.
- An out-of-window edge clears it.
- o_locked=1 exactly when the counter equals LOCK_CNT.
- o_locked deasserts in the cycle after the first out-of-window edge.
REQ-029 A change of i_lgcoeff takes effect on the next i_ce cycle and does not disturb lock state.

Reset
REQ-030 While i_reset=1, the block SHALL hold all state asynchronously at its reset value and ignore all inputs.
REQ-031 Reset values:
- phase=0, step=DEFAULT_STEP (clamped), o_err=0, o_locked=0, lock counter=0.
- Previous-input register=1, so a high reference level out of reset is not treated as an edge.
REQ-032 Reset asserted mid-operation SHALL abort any correction in flight; the first i_ce cycle after release behaves as the first after power-up.

Structure
REQ-033 Shared package dpll_pkg SHALL hold the err encoding constants (ERR_POS, ERR_ZERO, ERR_NEG) and the step clamp function.
REQ-034 Lock detection SHALL be one sub-module, dpll_lockdet, with inputs edge strobe, in-window flag and clear, and output locked.
REQ-035 All other logic SHALL be flat in dpll.

Verification
Bench parameters: PW=16, DEFAULT_STEP=16'h0400, LOCK_CNT=4, i_lgcoeff=4, i_ce=1 unless stated. These give P=16'h0400 and F=16'h0040.
REQ-036 Reference period of 64 i_ce cycles, rising exactly at the phase wrap -> o_err stays 0, o_step stays 16'h0400, o_locked=1 after the 4th edge.
REQ-037 Reference period of 60 cycles -> o_err=+1 on the early edges, o_step rises in 16'h0040 steps and settles near 16'h0444, o_locked asserts.
REQ-038 Locked loop, then one reference edge shifted by half a period -> o_err=-1 or +1, o_locked=0 on the next cycle, relock after 4 good edges.
REQ-039 i_ld=1 with i_step=16'hFFFF -> o_step=16'h7FFF; i_ld=1 with i_step=0 -> o_step=16'h0001; o_locked clears in both cases.
REQ-040 i_ce held low for 100 cycles with the reference toggling -> o_phase, o_step and o_locked unchanged, o_err=0.
REQ-041 i_reset pulsed mid-lock with i_input=1 -> outputs at reset values immediately; no edge is detected until i_input goes 0 and then 1.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared definitions for the digital PLL: phase-error encoding and step clamp.
package dpll_pkg;

  // Two's-complement phase-detector results carried on o_err.
  localparam logic [1:0] ERR_POS  = 2'b01;
  localparam logic [1:0] ERR_ZERO = 2'b00;
  localparam logic [1:0] ERR_NEG  = 2'b11;

  // Wide working width for signed step arithmetic; PW never exceeds 48.
  localparam int XW = 50;

  // Saturate a signed step candidate into [1, 2^(pw-1)-1]. A zero step would
  // stall the NCO and a step of half a cycle or more would alias.
  function automatic logic [47:0] clamp_step(input logic signed [XW-1:0] v,
                                             input int pw);
    logic signed [XW-1:0] hi;
    hi = (50'sd1 <<< (pw - 1)) - 50'sd1;
    if (v < 50'sd1)
      return 48'd1;
    else if (v > hi)
      return hi[47:0];
    else
      return v[47:0];
  endfunction

endpackage

// File: rtl/dpll_lockdet.sv
// Lock detector: counts consecutive in-window reference edges up to LOCK_CNT.
module dpll_lockdet #(
  parameter int LOCK_CNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic edge_stb,
  input  logic in_win,
  input  logic clr,
  output logic locked
);

  localparam int CW = $clog2(LOCK_CNT + 1);

  logic [CW-1:0] cnt;

  // Count good edges, saturating; any bad edge or a step load restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (edge_stb) begin
      if (!in_win)
        cnt <= '0;
      else if (cnt != CW'(LOCK_CNT))
        cnt <= cnt + CW'(1);
    end
  end

  assign locked = (cnt == CW'(LOCK_CNT));

endmodule

// File: rtl/dpll.sv
// Bang-bang digital PLL: NCO phase accumulator steered by a sign-only phase
// detector with proportional (phase) and integral (frequency) correction.
module dpll
  import dpll_pkg::*;
#(
  parameter int              PW           = 32,
  parameter int              OPW          = 8,
  parameter logic [PW-1:0]   DEFAULT_STEP = PW'(32'h0100_0000),
  parameter int              LOCK_CNT     = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_ce,
  input  logic           i_ld,
  input  logic [PW-1:0]  i_step,
  input  logic           i_input,
  input  logic [4:0]     i_lgcoeff,
  output logic [OPW-1:0] o_phase,
  output logic           o_clk,
  output logic [1:0]     o_err,
  output logic [PW-1:0]  o_step,
  output logic           o_locked
);

  localparam logic [PW-1:0] QUARTER  = {2'b01, {(PW-2){1'b0}}};
  localparam logic [PW-1:0] RST_STEP =
    PW'(clamp_step($signed({{(XW-PW){1'b0}}, DEFAULT_STEP}), PW));

  logic [PW-1:0]        phase;
  logic [PW-1:0]        step;
  logic [1:0]           err;
  logic                 prev_in;

  logic                 ref_edge;
  logic                 in_win;
  logic [1:0]           err_nxt;
  logic [PW-1:0]        p_gain;
  logic [PW-1:0]        f_gain;
  logic [5:0]           lg2;
  logic [PW-1:0]        phase_corr;
  logic signed [XW-1:0] step_adj;
  logic [PW-1:0]        phase_nxt;
  logic [PW-1:0]        step_nxt;
  logic [PW-1:0]        ld_step;

  assign ref_edge = i_ce & i_input & ~prev_in;
  assign in_win   = (phase[PW-1:PW-2] == 2'b00) || (phase[PW-1:PW-2] == 2'b11);
  assign lg2      = {i_lgcoeff, 1'b0};
  assign p_gain   = QUARTER >> i_lgcoeff;
  assign f_gain   = (lg2 >= 6'(PW - 2)) ? '0 : (QUARTER >> lg2);
  assign ld_step  = PW'(clamp_step($signed({{(XW-PW){1'b0}}, i_step}), PW));

  // Phase detector and correction terms for the current sample.
  always_comb begin
    err_nxt    = ERR_ZERO;
    phase_corr = '0;
    step_adj   = '0;
    if (ref_edge && !i_ld && (phase != '0))
      err_nxt = phase[PW-1] ? ERR_POS : ERR_NEG;
    if (err_nxt == ERR_POS) begin
      phase_corr = p_gain;
      step_adj   = $signed({{(XW-PW){1'b0}}, f_gain});
    end else if (err_nxt == ERR_NEG) begin
      phase_corr = -p_gain;
      step_adj   = -$signed({{(XW-PW){1'b0}}, f_gain});
    end
    phase_nxt = phase + step + phase_corr;
    step_nxt  = PW'(clamp_step($signed({{(XW-PW){1'b0}}, step}) + step_adj, PW));
  end

  // ---- stage p0 -> p1: loop state and registered detector output ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      phase   <= '0;
      step    <= RST_STEP;
      err     <= ERR_ZERO;
      prev_in <= 1'b1;
    end else begin
      if (i_ce)
        prev_in <= i_input;
      if (i_ld) begin
        step <= ld_step;
        err  <= ERR_ZERO;
        if (i_ce)
          phase <= phase + ld_step;
      end else if (i_ce) begin
        phase <= phase_nxt;
        step  <= step_nxt;
        err   <= err_nxt;
      end else begin
        err <= ERR_ZERO;
      end
    end
  end

  dpll_lockdet #(
    .LOCK_CNT (LOCK_CNT)
  ) u_lockdet (
    .clk      (i_clk),
    .rst      (i_reset),
    .edge_stb (ref_edge & ~i_ld),
    .in_win   (in_win),
    .clr      (i_ld),
    .locked   (o_locked)
  );

  assign o_phase = phase[PW-1 -: OPW];
  assign o_clk   = ~phase[PW-1];
  assign o_err   = err;
  assign o_step  = step;

endmodule

// File: tb/tb_dpll.sv
// Directed bench for dpll with PW=16, DEFAULT_STEP=16'h0400, LOCK_CNT=4,
// i_lgcoeff=4 (P=16'h0400, F=16'h0040).
module tb_dpll;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        ld = 1'b0;
  logic [15:0] step_in = '0;
  logic        inp = 1'b0;
  logic [4:0]  lg = 5'd4;
  logic [7:0]  o_phase;
  logic        o_clk;
  logic [1:0]  o_err;
  logic [15:0] o_step;
  logic        o_locked;

  int checks = 0;
  int errors = 0;

  dpll #(
    .PW           (16),
    .OPW          (8),
    .DEFAULT_STEP (16'h0400),
    .LOCK_CNT     (4)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_ce      (ce),
    .i_ld      (ld),
    .i_step    (step_in),
    .i_input   (inp),
    .i_lgcoeff (lg),
    .o_phase   (o_phase),
    .o_clk     (o_clk),
    .o_err     (o_err),
    .o_step    (o_step),
    .o_locked  (o_locked)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; ld = 1'b0; step_in = '0; inp = 1'b0; lg = 5'd4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cyc(input logic in_v);
    inp = in_v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_phase !== 8'h00) begin errors++; $display("FAIL rst_phase got %h want 00", o_phase); end
    checks++; if (o_step !== 16'h0400) begin errors++; $display("FAIL rst_step got %h want 0400", o_step); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", o_err); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", o_locked); end
    checks++; if (o_clk !== 1'b1) begin errors++; $display("FAIL rst_clk got %b want 1", o_clk); end
  endtask

  // Period 64 with rising edges exactly at the phase wrap (k = 64,128,192,256).
  task automatic test_locked_64();
    for (int k = 0; k <= 256; k++) begin
      cyc(k >= 64 && (k % 64) < 32);
      checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL p64_err k=%0d got %b want 00", k, o_err); end
      checks++; if (o_step !== 16'h0400) begin errors++; $display("FAIL p64_step k=%0d got %h want 0400", k, o_step); end
      if (k == 64) begin
        checks++; if (o_phase !== 8'h04) begin errors++; $display("FAIL p64_phase got %h want 04", o_phase); end
      end
      if (k == 192) begin
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL p64_early_lock got %b want 0", o_locked); end
      end
    end
    checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL p64_locked got %b want 1", o_locked); end
  endtask

  task automatic test_ce_hold();
    ce = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc(k[0]);
      checks++; if (o_phase !== 8'h04) begin errors++; $display("FAIL hold_phase k=%0d got %h want 04", k, o_phase); end
      checks++; if (o_step !== 16'h0400) begin errors++; $display("FAIL hold_step k=%0d got %h want 0400", k, o_step); end
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL hold_locked k=%0d got %b want 1", k, o_locked); end
      checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL hold_err k=%0d got %b want 00", k, o_err); end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_mid_lock();
    inp = 1'b1;
    cyc(1'b1);
    #3 rst = 1'b1;
    #1;
    checks++; if (o_phase !== 8'h00) begin errors++; $display("FAIL arst_phase got %h want 00", o_phase); end
    checks++; if (o_step !== 16'h0400) begin errors++; $display("FAIL arst_step got %h want 0400", o_step); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL arst_locked got %b want 0", o_locked); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL arst_err got %b want 00", o_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      cyc(k != 10);
      if (k < 11) begin
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL arst_noedge k=%0d got %b want 00", k, o_err); end
      end else begin
        checks++; if (o_err !== 2'b11) begin errors++; $display("FAIL arst_edge got %b want 11", o_err); end
      end
    end
  endtask

  // Period 60: edges at 60,120,180,240 see phases F000, F2C0, 0480, FFC0.
  task automatic test_freq_60();
    logic [1:0]  exp_err;
    logic [15:0] exp_step;
    do_reset();
    exp_step = 16'h0400;
    for (int k = 0; k <= 240; k++) begin
      cyc(k >= 60 && (k % 60) < 30);
      exp_err = 2'b00;
      case (k)
        60:  begin exp_err = 2'b01; exp_step = 16'h0440; end
        120: begin exp_err = 2'b01; exp_step = 16'h0480; end
        180: begin exp_err = 2'b11; exp_step = 16'h0440; end
        240: begin exp_err = 2'b01; exp_step = 16'h0480; end
        default: ;
      endcase
      checks++; if (o_err !== exp_err) begin errors++; $display("FAIL p60_err k=%0d got %b want %b", k, o_err, exp_err); end
      checks++; if (o_step !== exp_step) begin errors++; $display("FAIL p60_step k=%0d got %h want %h", k, o_step, exp_step); end
      if (k == 180) begin
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL p60_early_lock got %b want 0", o_locked); end
      end
    end
    checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL p60_locked got %b want 1", o_locked); end
  endtask

  // Lock on period 64, jump one edge to phase 8000, then relock on edges
  // at 303/305/307/309 (phases C380, D040, DD80, EB40).
  task automatic test_phase_jump();
    logic v;
    do_reset();
    for (int k = 0; k <= 309; k++) begin
      if (k < 64)       v = 1'b0;
      else if (k < 272) v = ((k % 64) < 32);
      else if (k < 288) v = 1'b0;
      else if (k < 296) v = 1'b1;
      else if (k < 303) v = 1'b0;
      else              v = k[0];
      cyc(v);
      if (k < 288) begin
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL jmp_pre_err k=%0d got %b want 00", k, o_err); end
      end
      if (k == 256) begin
        checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL jmp_locked got %b want 1", o_locked); end
      end
      if (k == 288) begin
        checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL jmp_err got %b want 01", o_err); end
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL jmp_unlock got %b want 0", o_locked); end
        checks++; if (o_step !== 16'h0440) begin errors++; $display("FAIL jmp_step got %h want 0440", o_step); end
      end
      if (k == 303) begin
        checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL relock_err got %b want 01", o_err); end
        checks++; if (o_step !== 16'h0480) begin errors++; $display("FAIL relock_step1 got %h want 0480", o_step); end
      end
      if (k == 307) begin
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", o_locked); end
      end
    end
    checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL relock_locked got %b want 1", o_locked); end
    checks++; if (o_step !== 16'h0540) begin errors++; $display("FAIL relock_step got %h want 0540", o_step); end
    checks++; if (o_phase !== 8'hF4) begin errors++; $display("FAIL relock_phase got %h want F4", o_phase); end
    checks++; if (o_clk !== 1'b0) begin errors++; $display("FAIL relock_clk got %b want 0", o_clk); end
  endtask

  // Loads from phase F440: clamp high with i_ce=1, then clamp low with i_ce=0.
  task automatic test_load();
    ld = 1'b1; ce = 1'b1; step_in = 16'hFFFF;
    cyc(1'b0);
    checks++; if (o_step !== 16'h7FFF) begin errors++; $display("FAIL ld_hi_step got %h want 7FFF", o_step); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL ld_hi_locked got %b want 0", o_locked); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL ld_hi_err got %b want 00", o_err); end
    checks++; if (o_phase !== 8'h74) begin errors++; $display("FAIL ld_hi_phase got %h want 74", o_phase); end
    ce = 1'b0; step_in = 16'h0000;
    cyc(1'b1);
    checks++; if (o_step !== 16'h0001) begin errors++; $display("FAIL ld_lo_step got %h want 0001", o_step); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL ld_lo_locked got %b want 0", o_locked); end
    checks++; if (o_phase !== 8'h74) begin errors++; $display("FAIL ld_lo_phase got %h want 74", o_phase); end
    ld = 1'b0; ce = 1'b1;
  endtask

  initial begin
    test_reset();
    test_locked_64();
    test_ce_hold();
    test_reset_mid_lock();
    test_freq_60();
    test_phase_jump();
    test_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
